// File: rtl/edusoc_fetch_pkg.sv
// Shared types and constants for the EduSoC instruction fetch front-end.
package edusoc_fetch_pkg;

    typedef enum logic [0:0] {
        FETCH = 1'b0,
        DRAIN = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_entry_t;

    localparam logic [31:0] INSTR_ALIGN_MASK = 32'hFFFF_FFFC;

endpackage

// File: rtl/edusoc_fetch_fifo.sv
// Registered prefetch FIFO of fetch entries; a pushed entry is visible at the head next cycle.
// Flush overrides push/pop; push is dropped when full and pop ignored when empty.
module edusoc_fetch_fifo
    import edusoc_fetch_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  fetch_entry_t push_data,
    input  logic         pop,
    input  logic         flush,
    output fetch_entry_t pop_data,
    output logic [CW-1:0] count,
    output logic         full,
    output logic         empty
);

    fetch_entry_t  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    // Storage is cleared on reset so the head reads as zero out of reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/edusoc_fetch_unit.sv
// Instruction fetch front-end: one outstanding bus transfer feeding a prefetch FIFO to decode.
// Bus outputs are registered; redirects flush the FIFO and discard any in-flight response.
module edusoc_fetch_unit
    import edusoc_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        CPU_CLK,
    input  logic        CPU_RES,
    output logic        INSTR_REQ,
    output logic [31:0] INSTR_ADDR,
    input  logic        INSTR_VALID,
    input  logic [31:0] INSTR_RDATA,
    output logic        FETCH_VALID,
    input  logic        FETCH_READY,
    output logic [31:0] FETCH_INSTR,
    output logic [31:0] FETCH_PC,
    input  logic        REDIRECT,
    input  logic [31:0] REDIRECT_PC
);

    localparam int CW = $clog2(DEPTH + 1);

    fetch_state_t  state;
    fetch_state_t  state_next;
    logic          outstanding;
    logic [31:0]   addr_q;
    // Next sequential fetch address; while draining it holds the redirect target.
    logic [31:0]   fetch_pc;
    logic [31:0]   pc_next;

    logic          done;
    logic          busy_next;
    logic          push;
    logic          pop;
    logic          issue;
    logic [CW-1:0] count;
    logic [CW-1:0] count_next;
    logic          fifo_full;
    logic          fifo_empty;
    fetch_entry_t  push_entry;
    fetch_entry_t  head;

    assign done       = outstanding && INSTR_VALID;
    assign push       = done && (state == FETCH) && !REDIRECT && !fifo_full;
    assign pop        = FETCH_VALID && FETCH_READY && !REDIRECT;
    assign push_entry = '{instr: INSTR_RDATA, pc: addr_q};

    always_comb begin
        state_next = state;
        pc_next    = fetch_pc;
        count_next = count + CW'(push) - CW'(pop);
        if (REDIRECT) begin
            pc_next    = REDIRECT_PC & INSTR_ALIGN_MASK;
            count_next = '0;
            state_next = (outstanding && !INSTR_VALID) ? DRAIN : FETCH;
        end else begin
            if (push) begin
                pc_next = fetch_pc + 32'd4;
            end
            if (state == DRAIN && done) begin
                state_next = FETCH;
            end
        end
    end

    // Issue against post-edge occupancy so the new transfer always has a free slot.
    assign busy_next = outstanding && !done;
    assign issue     = (state_next == FETCH) && !busy_next && (count_next < CW'(DEPTH));

    always_ff @(posedge CPU_CLK) begin
        if (CPU_RES) begin
            state       <= FETCH;
            outstanding <= 1'b0;
            addr_q      <= RESET_PC;
            fetch_pc    <= RESET_PC;
        end else begin
            state    <= state_next;
            fetch_pc <= pc_next;
            if (issue) begin
                outstanding <= 1'b1;
                addr_q      <= pc_next;
            end else if (done) begin
                outstanding <= 1'b0;
            end
        end
    end

    edusoc_fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (CPU_CLK),
        .rst       (CPU_RES),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .flush     (REDIRECT),
        .pop_data  (head),
        .count     (count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign INSTR_REQ   = outstanding;
    assign INSTR_ADDR  = addr_q;
    assign FETCH_VALID = !fifo_empty;
    assign FETCH_INSTR = head.instr;
    assign FETCH_PC    = head.pc;

endmodule

// File: tb/tb_edusoc_fetch_unit.sv
// Directed bench for edusoc_fetch_unit with a wait-state memory model and a second
// zero-wait instance reset to the top of the address space to exercise PC wrap.
module tb_edusoc_fetch_unit;

    logic        clk = 1'b0;
    logic        res = 1'b1;
    logic        req;
    logic [31:0] addr;
    logic        ivalid;
    logic [31:0] rdata;
    logic        fvalid;
    logic        fready = 1'b1;
    logic [31:0] finstr;
    logic [31:0] fpc;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;

    logic        w_req;
    logic [31:0] w_addr;
    logic        w_fvalid;
    logic [31:0] w_finstr;
    logic [31:0] w_fpc;

    int waits = 0;
    int wcnt  = 0;
    int n_chk = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    // Memory: responds after `waits` extra cycles, word = addr ^ A5A5A5A5.
    assign ivalid = req && (wcnt >= waits);
    assign rdata  = addr ^ 32'hA5A5_A5A5;
    always @(posedge clk) begin
        if (res || !req || ivalid) wcnt <= 0;
        else wcnt <= wcnt + 1;
    end

    edusoc_fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
        .CPU_CLK     (clk),
        .CPU_RES     (res),
        .INSTR_REQ   (req),
        .INSTR_ADDR  (addr),
        .INSTR_VALID (ivalid),
        .INSTR_RDATA (rdata),
        .FETCH_VALID (fvalid),
        .FETCH_READY (fready),
        .FETCH_INSTR (finstr),
        .FETCH_PC    (fpc),
        .REDIRECT    (redirect),
        .REDIRECT_PC (redirect_pc)
    );

    edusoc_fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(2)) dut_w (
        .CPU_CLK     (clk),
        .CPU_RES     (res),
        .INSTR_REQ   (w_req),
        .INSTR_ADDR  (w_addr),
        .INSTR_VALID (w_req),
        .INSTR_RDATA (w_addr ^ 32'hA5A5_A5A5),
        .FETCH_VALID (w_fvalid),
        .FETCH_READY (1'b1),
        .FETCH_INSTR (w_finstr),
        .FETCH_PC    (w_fpc),
        .REDIRECT    (1'b0),
        .REDIRECT_PC (32'h0)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves reset released just after an edge that still saw it high.
    task automatic do_reset(input int w, input logic rdy);
        res = 1'b1;
        redirect = 1'b0;
        tick();
        tick();
        waits = w;
        fready = rdy;
        res = 1'b0;
    endtask

    initial begin
        int got;
        int hi;
        int seen8;

        // Reset values and zero-wait streaming from reset
        waits = 0;
        fready = 1'b1;
        tick();
        tick();
        check_eq("rst_req", req, 0);
        check_eq("rst_addr", addr, 32'h0);
        check_eq("rst_fvalid", fvalid, 0);
        check_eq("rst_finstr", finstr, 32'h0);
        check_eq("rst_fpc", fpc, 32'h0);
        check_eq("rst_w_addr", w_addr, 32'hFFFF_FFF8);
        res = 1'b0;
        tick();
        check_eq("t1_req_rise", req, 1);
        check_eq("t1_fvalid_early", fvalid, 0);
        tick();
        for (int i = 0; i < 6; i++) begin
            check_eq("t1_fvalid", fvalid, 1);
            check_eq("t1_fpc", fpc, 32'(4 * i));
            check_eq("t1_finstr", finstr, 32'(4 * i) ^ 32'hA5A5_A5A5);
            if (i < 3) check_eq("t5_wrap_fpc", w_fpc, 32'hFFFF_FFF8 + 32'(4 * i));
            tick();
        end

        // Three wait states, decode stalled: FIFO fills to DEPTH then fetch stops
        do_reset(3, 1'b0);
        tick();
        check_eq("t2_req_rise", req, 1);
        got = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (!req) begin
                got = 1;
                break;
            end
        end
        check_eq("t2_req_stops", got, 1);
        check_eq("t2_fvalid", fvalid, 1);
        check_eq("t2_head0", fpc, 32'h0);
        hi = 0;
        repeat (8) begin
            tick();
            if (req) hi++;
        end
        check_eq("t2_req_idle", hi, 0);
        check_eq("t2_head_stable", fpc, 32'h0);
        fready = 1'b1;
        tick();
        check_eq("t2_head1", fpc, 32'h4);
        check_eq("t2_instr1", finstr, 32'hA5A5_A5A1);
        check_eq("t2_resume_req", req, 1);
        check_eq("t2_resume_addr", addr, 32'h8);
        tick();
        check_eq("t2_drained", fvalid, 0);

        // Redirect while the addr-8 transfer is waiting
        redirect = 1'b1;
        redirect_pc = 32'h0000_0103;
        tick();
        redirect = 1'b0;
        check_eq("t3_hold_req", req, 1);
        check_eq("t3_hold_addr", addr, 32'h8);
        check_eq("t3_flushed", fvalid, 0);
        got = 0;
        seen8 = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (fvalid && fpc == 32'h8) seen8++;
            if (addr != 32'h8) begin
                got = 1;
                break;
            end
        end
        check_eq("t3_drain_done", got, 1);
        check_eq("t3_target_addr", addr, 32'h0000_0100);
        check_eq("t3_target_req", req, 1);
        check_eq("t3_discarded", fvalid, 0);
        got = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (fvalid && fpc == 32'h8) seen8++;
            if (fvalid) begin
                got = 1;
                break;
            end
        end
        check_eq("t3_target_arrives", got, 1);
        check_eq("t3_target_fpc", fpc, 32'h0000_0100);
        check_eq("t3_target_instr", finstr, 32'hA5A5_A4A5);
        check_eq("t3_no_pc8", seen8, 0);

        // Redirect coinciding with the addr-4 completion
        do_reset(0, 1'b0);
        tick();
        check_eq("t4_addr0", addr, 32'h0);
        tick();
        check_eq("t4_addr4", addr, 32'h4);
        check_eq("t4_valid4", ivalid, 1);
        redirect = 1'b1;
        redirect_pc = 32'h0000_0200;
        tick();
        redirect = 1'b0;
        check_eq("t4_target_addr", addr, 32'h0000_0200);
        check_eq("t4_target_req", req, 1);
        check_eq("t4_empty", fvalid, 0);
        tick();
        check_eq("t4_fvalid", fvalid, 1);
        check_eq("t4_fpc", fpc, 32'h0000_0200);
        check_eq("t4_finstr", finstr, 32'hA5A5_A7A5);

        // Reset mid-transfer with one buffered entry
        do_reset(3, 1'b0);
        got = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (fvalid) begin
                got = 1;
                break;
            end
        end
        check_eq("t6_first_word", got, 1);
        check_eq("t6_fpc0", fpc, 32'h0);
        check_eq("t6_addr4", addr, 32'h4);
        tick();
        res = 1'b1;
        tick();
        check_eq("t6_rst_req", req, 0);
        check_eq("t6_rst_fvalid", fvalid, 0);
        check_eq("t6_rst_addr", addr, 32'h0);
        check_eq("t6_rst_fpc", fpc, 32'h0);
        res = 1'b0;
        waits = 0;
        fready = 1'b1;
        tick();
        check_eq("t6_restart_req", req, 1);
        check_eq("t6_restart_addr", addr, 32'h0);
        tick();
        check_eq("t6_restart_fpc0", fpc, 32'h0);
        tick();
        check_eq("t6_restart_fpc1", fpc, 32'h4);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/edusoc_fetch_unit.md
# edusoc_fetch_unit

Instruction fetch front-end for cores attached to the EduSoC core-side instruction memory interface. Drives INSTR_REQ/INSTR_ADDR, consumes INSTR_VALID/INSTR_RDATA, and buffers fetched words in a small prefetch FIFO. The FIFO feeds the core decode stage over a valid/ready handshake. Supports redirects (branch, jump, trap) with flush and discard of any in-flight bus transfer.

## Interface
- RESET_PC, 32'h0000_0000: first fetch address after reset; bits [1:0] must be zero.
- DEPTH, 2: prefetch FIFO entries; power of two, at least 2.

Ports:
- CPU_CLK  in  1  core clock; all logic on the rising edge.
- CPU_RES  in  1  reset, synchronous, active-high.
- INSTR_REQ  out  1  bus request.
- INSTR_ADDR  out  32  word-aligned fetch address.
- INSTR_VALID  in  1  bus transfer complete; INSTR_RDATA valid this cycle.
- INSTR_RDATA  in  32  fetched instruction word.
- FETCH_VALID  out  1  FIFO head is valid.
- FETCH_READY  in  1  decode accepts the head.
- FETCH_INSTR  out  32  head instruction.
- FETCH_PC  out  32  head address.
- REDIRECT  in  1  one-cycle pulse; flush and restart at REDIRECT_PC.
- REDIRECT_PC  in  32  new fetch address; bits [1:0] are ignored and forced to 0.

## Operation
- Bus rule: a transfer completes in the cycle where INSTR_REQ && INSTR_VALID. INSTR_ADDR stays stable and INSTR_REQ stays high until then. INSTR_VALID may arrive in the same cycle as INSTR_REQ or any later cycle. At most one transfer is outstanding. A new request may be presented in the cycle after completion.
- Issue condition: in state FETCH, a new request is issued only when occupancy plus outstanding transfers is less than DEPTH. The FIFO can therefore never overflow.
- fetch_pc register: increments by 4 on each completed, non-discarded transfer and wraps modulo 2^32 (32'hFFFF_FFFC goes to 0).
- States:
  - FETCH: normal issue. Completion pushes {INSTR_RDATA, INSTR_ADDR}.
  - DRAIN: a redirect arrived while a transfer was outstanding. INSTR_REQ and INSTR_ADDR stay held at the old values until INSTR_VALID. That response is discarded, then the state returns to FETCH and requests resume at the stored target.
- Redirect:
  - The FIFO is cleared, FETCH_VALID goes low the next cycle, and fetch_pc is set to the target.
  - If no transfer is outstanding, or one completes in the same cycle, the next state is FETCH. Otherwise the next state is DRAIN.
- Priorities and simultaneous events:
  - REDIRECT beats FIFO push and pop. A response completing in the redirect cycle is discarded.
  - A REDIRECT during DRAIN only updates the stored target; the state stays DRAIN.
  - When full, push and pop in the same cycle cannot both occur, because the issue condition prevents it. When not full, both take effect together.
- Output handshake: the head is popped on FETCH_VALID && FETCH_READY. FETCH_INSTR and FETCH_PC stay stable while FETCH_VALID && !FETCH_READY.
- Reset, including mid-transfer: state goes to FETCH, the FIFO empties, and fetch_pc = RESET_PC. The bus side is reset together with the core, so no drain is needed.

## Timing
- Reset values: INSTR_REQ=0, INSTR_ADDR=RESET_PC, FETCH_VALID=0, FETCH_INSTR=0, FETCH_PC=0.
- INSTR_REQ rises in the first cycle after CPU_RES deasserts.
- FIFO is registered: a word completing in cycle n appears on FETCH_VALID in cycle n+1.
- Redirect at cycle n with no outstanding transfer: INSTR_REQ with INSTR_ADDR=target at n+1; earliest FETCH_VALID of the target word is n+2 with a zero-wait bus.
- Throughput: one word per cycle with a zero-wait bus, as long as decode is ready.
- INSTR_REQ and INSTR_ADDR are registered outputs and have no combinational path from INSTR_VALID.

## Structure
- Package edusoc_fetch_pkg contains:
  - state enum fetch_state_t {FETCH, DRAIN};
  - typedef fetch_entry_t struct {instr[31:0], pc[31:0]};
  - constant INSTR_ALIGN_MASK = 32'hFFFF_FFFC.
- Sub-module edusoc_fetch_fifo: synchronous FIFO of fetch_entry_t, parameter DEPTH, with push, pop, flush, count, full and empty. Pointers wrap modulo DEPTH. Flush takes priority over push and pop.
- The top level holds the state machine, fetch_pc, the stored redirect target and the outstanding flag.

## Test plan
- Zero-wait memory returning word = addr ^ 32'hA5A5_A5A5, FETCH_READY=1 from reset -> FETCH_PC sequence 0,4,8,… one per cycle; first FETCH_VALID is 2 cycles after reset release.
- Memory with 3 wait states and FETCH_READY=0 -> exactly DEPTH (2) words are buffered and INSTR_REQ stays low afterwards. Raising FETCH_READY drains PC 0 then 4, and fetching resumes at 8.
- REDIRECT to 32'h0000_0103 during a 3-wait transfer to addr 8 -> DRAIN; the addr-8 response is discarded; the next request is 32'h0000_0100, and FETCH_PC 8 never appears.
- REDIRECT in the same cycle as INSTR_VALID for addr 4 -> word 4 is discarded, INSTR_ADDR equals the target on the next cycle, and the FIFO is empty.
- RESET_PC=32'hFFFF_FFF8, zero-wait memory -> FETCH_PC sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
- CPU_RES asserted mid-transfer with the FIFO holding 1 entry -> next cycle INSTR_REQ=0, FETCH_VALID=0, INSTR_ADDR=RESET_PC; fetching restarts cleanly after release.
